// File: rtl/datapoint_loader.sv
// Pairs 16-bit X/Y samples into 32-bit words and writes them sequentially to a data-point memory.
// Optional LOADER_WRAP_EN: wrap at MAX_WORDS and keep loading (ring buffer) instead of closing.
module datapoint_loader #(
    parameter int AW        = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    input  logic          in_last,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          done,
    output logic          err_odd
);

    typedef enum logic [1:0] {GET_X, GET_Y, WRITE, DONE} state_t;

    localparam logic [AW:0]   MAX_CNT   = (AW+1)'(MAX_WORDS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_WORDS - 1);

    state_t        state_q, state_d;
    logic [15:0]   x_q, x_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          last_q, last_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          err_odd_q, err_odd_d;
    logic [AW:0]   count_inc;
    logic          accept;

    // Gating with reset keeps handshake and strobe quiet during the reset cycle itself.
    assign in_ready = reset && ((state_q == GET_X) || (state_q == GET_Y));
    assign we       = reset && (state_q == WRITE);
    assign accept   = in_valid && in_ready;
    assign count_inc = (count_q == MAX_CNT) ? count_q : count_q + (AW+1)'(1);

    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign count   = count_q;
    assign full    = full_q;
    assign done    = (state_q == DONE);
    assign err_odd = err_odd_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        wdata_d   = wdata_q;
        last_d    = last_q;
        waddr_d   = waddr_q;
        count_d   = count_q;
        err_odd_d = err_odd_q;
`ifdef LOADER_WRAP_EN
        full_d    = 1'b0;
`else
        full_d    = full_q;
`endif
        case (state_q)
            GET_X: begin
                if (accept) begin
                    if (in_last) begin
                        err_odd_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        x_d     = in_data;
                        state_d = GET_Y;
                    end
                end
            end
            GET_Y: begin
                if (accept) begin
                    wdata_d = {x_q, in_data};
                    last_d  = in_last;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                count_d = count_inc;
`ifdef LOADER_WRAP_EN
                if (waddr_q == LAST_ADDR) begin
                    waddr_d = '0;
                    full_d  = 1'b1;
                end else begin
                    waddr_d = waddr_q + AW'(1);
                end
                state_d = last_q ? DONE : GET_X;
`else
                waddr_d = waddr_q + AW'(1);
                full_d  = (count_inc == MAX_CNT);
                state_d = (last_q || (count_inc == MAX_CNT)) ? DONE : GET_X;
`endif
            end
            DONE: state_d = DONE;
            default: state_d = GET_X;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= GET_X;
            x_q       <= '0;
            wdata_q   <= '0;
            last_q    <= 1'b0;
            waddr_q   <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            err_odd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            wdata_q   <= wdata_d;
            last_q    <= last_d;
            waddr_q   <= waddr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            err_odd_q <= err_odd_d;
        end
    end

endmodule

// File: tb/tb_datapoint_loader.sv
// Directed bench for datapoint_loader (AW=3, MAX_WORDS=4); honours LOADER_WRAP_EN for the limit test.
module tb_datapoint_loader;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_last, we, full, done, err_odd;
    logic [15:0] in_data;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;
    int we_cnt, acc_cnt, full_cnt;
    logic [2:0]  we_addr[16];
    logic [31:0] we_data[16];

    datapoint_loader #(.AW(3), .MAX_WORDS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .we(we), .waddr(waddr),
        .wdata(wdata), .count(count), .full(full), .done(done), .err_odd(err_odd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we && we_cnt < 16) begin
            we_addr[we_cnt] = waddr;
            we_data[we_cnt] = wdata;
            we_cnt = we_cnt + 1;
        end
        if (in_valid && in_ready) acc_cnt = acc_cnt + 1;
        if (full) full_cnt = full_cnt + 1;
    end

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        we_cnt = 0; acc_cnt = 0; full_cnt = 0;
        reset = 1'b1;
    endtask

    task automatic send(input logic [15:0] d, input logic l, input int max_cyc, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_chk(input logic [15:0] d, input logic l);
        bit ok;
        send(d, l, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL accept_timeout data=%h not accepted within bound", d); end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_data = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({we, in_ready, full, done, err_odd} !== 5'b0 || waddr !== 3'd0 || count !== 4'd0 || wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_state we=%b rdy=%b full=%b done=%b err=%b waddr=%0d count=%0d wdata=%h expected all zero",
                     we, in_ready, full, done, err_odd, waddr, count, wdata);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_pair();
        do_reset();
        send_chk(16'h1234, 1'b0);
        send_chk(16'h5678, 1'b1);
        checks++;
        if (we !== 1'b1 || waddr !== 3'd0 || wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL single_write we=%b waddr=%0d wdata=%h exp we=1 waddr=0 wdata=12345678", we, waddr, wdata);
        end
        @(posedge clk);
        #1;
        checks++;
        if (count !== 4'd1 || done !== 1'b1 || in_ready !== 1'b0 || we !== 1'b0) begin
            errors++;
            $display("FAIL single_after count=%0d done=%b rdy=%b we=%b exp 1 1 0 0", count, done, in_ready, we);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (we_cnt !== 1 || done !== 1'b1) begin errors++; $display("FAIL single_sticky writes=%0d done=%b exp 1 1", we_cnt, done); end
    endtask

    task automatic test_toggle();
        do_reset();
        for (int p = 1; p <= 3; p++) begin
            send_chk(16'hA000 + 16'(p), 1'b0);
            @(posedge clk);
            #1;
            send_chk(16'hB000 + 16'(p), 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (we_cnt !== 3 || acc_cnt !== 6 || count !== 4'd3) begin
            errors++;
            $display("FAIL toggle_counts writes=%0d accepts=%0d count=%0d exp 3 6 3", we_cnt, acc_cnt, count);
        end
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (we_addr[p] !== 3'(p) || we_data[p] !== {16'hA000 + 16'(p+1), 16'hB000 + 16'(p+1)}) begin
                errors++;
                $display("FAIL toggle_write%0d waddr=%0d wdata=%h exp waddr=%0d wdata=%h", p, we_addr[p], we_data[p],
                         p, {16'hA000 + 16'(p+1), 16'hB000 + 16'(p+1)});
            end
        end
    endtask

    task automatic test_limit();
        bit ok;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            send_chk(16'h1000 + 16'(p), 1'b0);
            send_chk(16'h2000 + 16'(p), 1'b0);
        end
`ifdef LOADER_WRAP_EN
        send_chk(16'h1004, 1'b0);
        send_chk(16'h2004, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (we_cnt !== 5 || we_addr[4] !== 3'd0 || we_data[4] !== 32'h10042004) begin
            errors++;
            $display("FAIL wrap_fifth writes=%0d waddr=%0d wdata=%h exp 5 0 10042004", we_cnt, we_addr[4], we_data[4]);
        end
        checks++;
        if (full_cnt !== 1 || done !== 1'b0 || count !== 4'd4 || full !== 1'b0) begin
            errors++;
            $display("FAIL wrap_status full_cycles=%0d done=%b count=%0d full=%b exp 1 0 4 0", full_cnt, done, count, full);
        end
`else
        send(16'h1004, 1'b0, 8, ok);
        checks++;
        if (ok !== 1'b0 || acc_cnt !== 8) begin
            errors++;
            $display("FAIL limit_fifth accepted=%b accepts=%0d exp 0 8", ok, acc_cnt);
        end
        checks++;
        if (we_cnt !== 4 || we_addr[3] !== 3'd3 || we_data[3] !== 32'h10032003) begin
            errors++;
            $display("FAIL limit_writes writes=%0d waddr=%0d wdata=%h exp 4 3 10032003", we_cnt, we_addr[3], we_data[3]);
        end
        checks++;
        if (full !== 1'b1 || done !== 1'b1 || count !== 4'd4) begin
            errors++;
            $display("FAIL limit_status full=%b done=%b count=%0d exp 1 1 4", full, done, count);
        end
`endif
    endtask

    task automatic test_odd_last();
        do_reset();
        send_chk(16'h0001, 1'b0);
        send_chk(16'h0002, 1'b0);
        send_chk(16'h0003, 1'b1);
        checks++;
        if (err_odd !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL odd_flags err_odd=%b done=%b exp 1 1", err_odd, done);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (we_cnt !== 1 || count !== 4'd1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL odd_writes writes=%0d count=%0d rdy=%b exp 1 1 0", we_cnt, count, in_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        send_chk(16'hDEAD, 1'b0);
        send_chk(16'hBEEF, 1'b0);
        reset = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL midreset_we got=%b exp 0", we); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (we_cnt !== 0 || count !== 4'd0 || waddr !== 3'd0) begin
            errors++;
            $display("FAIL midreset_state writes=%0d count=%0d waddr=%0d exp 0 0 0", we_cnt, count, waddr);
        end
        send_chk(16'hCAFE, 1'b0);
        send_chk(16'hF00D, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (we_cnt !== 1 || we_addr[0] !== 3'd0 || we_data[0] !== 32'hCAFEF00D || count !== 4'd1) begin
            errors++;
            $display("FAIL midreset_next writes=%0d waddr=%0d wdata=%h count=%0d exp 1 0 cafef00d 1",
                     we_cnt, we_addr[0], we_data[0], count);
        end
    endtask

    initial begin
        we_cnt = 0; acc_cnt = 0; full_cnt = 0;
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        test_reset();
        test_single_pair();
        test_toggle();
        test_limit();
        test_odd_last();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
